dh_modexp_engine: RTL
=====================

DH_MODEXP_ENGINE -- requirements
Module: dh_modexp_engine

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port base  input  N  generator or received public value.
REQ-006 SHALL have port exponent  input  N  private key.
REQ-007 SHALL have port modulus  input  N  prime modulus.
REQ-008 SHALL have port busy  output  1  high while a computation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  N  base^exponent mod modulus.
REQ-011 SHALL have port err  output  1  modulus-zero flag for the last request.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-013 IDLE with start=1: SHALL register base%modulus, exponent and modulus, set the accumulator to 1%modulus, clear the bit counter and go to RUN.
REQ-014 Each RUN cycle SHALL do acc<=(acc*b)%m when exp[0]=1, else hold acc, and SHALL do b<=(b*b)%m and exp<=exp>>1; products are 2N bits wide and never truncated before reduction.
REQ-015 RUN SHALL last exactly N cycles, then go to DONE.
REQ-016 DONE SHALL last one cycle with done=1, load result from acc, then return to IDLE.
REQ-017 Latency SHALL be fixed: done is high in the cycle N+1 edges after the edge that accepted start (N=8: 9 cycles).
REQ-018 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored while busy=1, with no queuing and no effect on the operation in flight.
REQ-020 result and err SHALL hold their values until the next DONE cycle.
REQ-021 modulus=0 SHALL give err=1 and result=0 at DONE, with normal latency and no division by zero.
REQ-022 modulus=1 SHALL give result=0 and err=0.
REQ-023 exponent=0 SHALL give result=1%modulus.
REQ-024 base>=modulus SHALL be reduced at load, so the result equals the mathematical modexp.
REQ-025 start held continuously SHALL restart a new computation on the first IDLE cycle after DONE.

Reset
REQ-026 reset=0 at a rising edge SHALL force IDLE and clear busy, done, err, result and all internal registers to 0, from any state.
REQ-027 A reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL begin a fresh computation.

Configuration
REQ-028 With macro DH_EARLY_EXIT_EN defined, RUN SHALL end after the cycle in which the shifted exponent becomes 0, with a minimum of one RUN cycle.
REQ-029 With DH_EARLY_EXIT_EN defined, latency SHALL be max(1, msb_index+1)+1 cycles, and results SHALL be identical to the fixed-latency build.
REQ-030 Without DH_EARLY_EXIT_EN, latency SHALL be fixed per REQ-017.

Verification
REQ-031 N=8, base=5, exponent=6, modulus=23 -> result=8, err=0; done 9 cycles after start (4 cycles with DH_EARLY_EXIT_EN).
REQ-032 Key exchange: (5,15,23) -> 19; then (19,6,23) -> 2 and (8,15,23) -> 2, giving matching shared secrets.
REQ-033 Corners: (7,0,23) -> 1; (30,1,23) -> 7; (9,5,1) -> 0; (9,5,0) -> result=0, err=1.
REQ-034 Pulse start again 3 cycles into (5,6,23) with other operands -> single done, result=8, busy high throughout.
REQ-035 Assert reset at RUN cycle 4 -> all outputs 0 next cycle, no done pulse; the next request (5,15,23) returns 19.
REQ-036 Random regression, N=8 and N=16, 1000 operand sets -> result matches reference modexp; done is exactly one cycle wide.

Source files
------------

// File: rtl/dh_modexp_engine.sv
// -----------------------------------------------------------------------------
// dh_modexp_engine
//
// Purpose
//   Computes result = base^exponent mod modulus for Diffie-Hellman style key
//   exchange using right-to-left square-and-multiply. One exponent bit is
//   consumed per RUN cycle; each cycle performs one modular multiply of the
//   accumulator and one modular square of the running base. Products are kept
//   at full 2N-bit width and reduced with a single remainder operation.
//
// Parameters
//   N         operand width in bits, legal range 2..32 (default 8)
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous, active-low reset
//   start     request pulse, only sampled while idle
//   base      generator or received public value
//   exponent  private key
//   modulus   prime modulus
//   busy      high while a computation is in progress (RUN and DONE)
//   done      one-cycle completion pulse, coincident with result/err update
//   result    base^exponent mod modulus, held until the next completion
//   err       set when the last request had modulus == 0, held likewise
//
// Timing
//   The edge that accepts start enters RUN. RUN lasts N cycles, DONE lasts
//   one cycle, and the edge leaving DONE registers result/err together with
//   the done pulse, so done is high N+1 edges after the accepting edge.
//   busy drops in that same cycle, so a held start is accepted immediately.
//
// Configuration
//   DH_EARLY_EXIT_EN  when defined, RUN ends after the cycle in which the
//                     shifted exponent becomes zero (minimum one RUN cycle),
//                     giving latency max(1, msb_index+1)+1. Results are
//                     identical because the remaining cycles only square a
//                     base that is never multiplied in again.
// -----------------------------------------------------------------------------
module dh_modexp_engine #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] base,
  input  logic [N-1:0] exponent,
  input  logic [N-1:0] modulus,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         err
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The bit counter must hold the value N after the last RUN increment.
  localparam int              CW       = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [N-1:0]  r_acc;      // running product of selected base powers
  logic [N-1:0]  r_b;        // base^(2^k) mod m for the current bit k
  logic [N-1:0]  r_exp;      // exponent, shifted right once per RUN cycle
  logic [N-1:0]  r_mod;      // modulus latched for the whole operation
  logic [CW-1:0] r_cnt;      // RUN cycles completed
  logic          r_done;
  logic [N-1:0]  r_result;
  logic          r_err;

  // ---------------------------------------------------------------------------
  // Datapath wires
  // ---------------------------------------------------------------------------
  logic [2*N-1:0] w_acc_prod;
  logic [2*N-1:0] w_b_sq;
  logic [N-1:0]   w_acc_mul;
  logic [N-1:0]   w_b_next;
  logic [N-1:0]   w_exp_next;
  logic [N-1:0]   w_b_load;
  logic [N-1:0]   w_acc_init;
  logic           w_mod_zero;
  logic           w_run_last;

  // Remainder of a 2N-bit value by an N-bit modulus. A zero modulus yields
  // zero so no divide-by-zero is ever evaluated; the remainder is always
  // smaller than the modulus, so narrowing it back to N bits loses nothing.
  function automatic logic [N-1:0] mod_reduce(
    input logic [2*N-1:0] x,
    input logic [N-1:0]   m
  );
    if (m == '0) begin
      return '0;
    end
    return N'(x % {{N{1'b0}}, m});
  endfunction

  // Full-width products: both operands are zero-extended to 2N bits first so
  // the multiply is never truncated ahead of the reduction.
  assign w_acc_prod = {{N{1'b0}}, r_acc} * {{N{1'b0}}, r_b};
  assign w_b_sq     = {{N{1'b0}}, r_b}   * {{N{1'b0}}, r_b};

  assign w_acc_mul  = mod_reduce(w_acc_prod, r_mod);
  assign w_b_next   = mod_reduce(w_b_sq, r_mod);
  assign w_exp_next = r_exp >> 1;

  // Load-time reduction: base >= modulus is folded here, and the accumulator
  // starts at 1 % modulus, which is 0 for modulus 0 or 1.
  assign w_b_load   = mod_reduce({{N{1'b0}}, base}, modulus);
  assign w_acc_init = mod_reduce({{(2*N-1){1'b0}}, 1'b1}, modulus);

  assign w_mod_zero = (r_mod == '0);

`ifdef DH_EARLY_EXIT_EN
  // Stop once no set exponent bits remain. The counter cap is redundant for
  // an N-bit exponent but keeps RUN bounded by construction.
  assign w_run_last = (w_exp_next == '0) || (r_cnt == CNT_LAST);
`else
  assign w_run_last = (r_cnt == CNT_LAST);
`endif

  // ---------------------------------------------------------------------------
  // Control and datapath state
  // ---------------------------------------------------------------------------
  // NOTE: every register here, including the datapath ones, is cleared on
  // reset so outputs and internal state are fully defined after an abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state is always assigned non-blocking so every
      // register samples the pre-edge values of the others.
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_b      <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the DONE branch raises it.
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b     <= w_b_load;
            r_exp   <= exponent;
            r_mod   <= modulus;
            r_acc   <= w_acc_init;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (r_exp[0]) begin
            r_acc <= w_acc_mul;
          end
          r_b   <= w_b_next;
          r_exp <= w_exp_next;
          r_cnt <= r_cnt + CNT_ONE;
          if (w_run_last) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // With a zero modulus the accumulator is already zero, but the
          // result is forced explicitly so the error case never depends on it.
          r_result <= w_mod_zero ? '0 : r_acc;
          r_err    <= w_mod_zero;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // start is only acted on in IDLE, so anything arriving while busy is
  // dropped without affecting the operation in flight.
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;

endmodule
